harris_frame_ctrl: RTL
======================

Name: harris_frame_ctrl

Overview:
- Frame-level sequencer for the Harris corner datapath.
- Counts active pixels in raster order and generates the detector's clk_en.
- Flushes the detector's window/pipeline latency at end of frame.
- Maps each detector decision back to (x, y) of the window centre, masks border decisions, applies threshold/scale updates only at frame boundaries, and reports a per-frame corner count.
- Sits between the VGA pixel stream and the corner overlay/readout logic.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- LATENCY, 1283, enabled cycles from a pixel entering the detector to its window-centre decision (2*H_ACTIVE+3).
- BORDER, 3, pixels masked at each image edge; decisions there are invalid.
- CNT_W, 20, width of the corner counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sof  in  1  start-of-frame pulse, one cycle
- pix_valid  in  1  active-pixel strobe from the VGA stream
- corner_in  in  1  corner_detected from the detector
- cfg_threshold  in  18  signed pending threshold
- cfg_scale  in  8  pending trace scale
- cfg_load  in  1  pulse: capture cfg_* into the pending registers
- det_clk_en  out  1  clk_en to the detector
- det_threshold  out  18  signed active threshold
- det_scale  out  8  active scale
- corner_valid  out  1  one-cycle strobe: corner at corner_x/corner_y
- corner_x  out  10  column of the reported decision
- corner_y  out  9  row of the reported decision
- frame_done  out  1  one-cycle pulse at end of frame
- corner_count  out  CNT_W  corners in last completed frame
- frame_err  out  1  sticky: frame aborted by early sof
- busy  out  1  high in ACTIVE or DRAIN

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0, except det_threshold=18'sd0 and det_scale=8'd0 (the pending registers also reset to 0).
  - All counters cleared.
  - A reset mid-frame discards the frame; no frame_done is produced.
- States:
  - IDLE: det_clk_en=0. On sof: copy pending cfg to det_threshold/det_scale, clear counters, go to ACTIVE.
  - ACTIVE: det_clk_en=pix_valid. Input counter in_cnt increments per enabled cycle. When in_cnt reaches H_ACTIVE*V_ACTIVE, go to DRAIN.
  - DRAIN: det_clk_en=1 for exactly LATENCY cycles, which pushes filler data through the detector. Then go to DONE.
  - DONE: one cycle. frame_done=1; corner_count<=running count; go to IDLE.
- Decision alignment:
  - en_d is det_clk_en delayed by one clk (corner_in is registered in the detector).
  - Enabled-cycle counter tot increments on det_clk_en.
  - An output position is produced on each en_d cycle for which (tot-1) >= LATENCY.
  - The output raster counter (ox, oy) starts at (0,0). ox wraps at H_ACTIVE-1 to 0 with oy+1.
  - Exactly H_ACTIVE*V_ACTIVE output positions are produced per frame.
- Masking:
  - corner_valid = output position produced AND corner_in AND BORDER <= ox < H_ACTIVE-BORDER AND BORDER <= oy < V_ACTIVE-BORDER.
  - corner_x/corner_y are registered alongside corner_valid and hold their value otherwise.
- Counting:
  - The running count increments per corner_valid and saturates at all-ones.
  - corner_count holds the last completed frame's value until the next DONE.
- Config:
  - cfg_load in any state updates only the pending registers.
  - Active values change only on the IDLE→ACTIVE transition, so mid-frame loads never affect the current frame.
- Boundary conditions:
  - sof in ACTIVE, DRAIN or DONE: set frame_err (cleared only by reset), abort the frame with no frame_done, restart as if from IDLE with the pending cfg applied.
  - pix_valid in IDLE: ignored.
  - pix_valid in DRAIN: ignored; det_clk_en stays 1.
  - sof and cfg_load in the same cycle: the new cfg is captured into pending first and applied to this frame.

Optional Feature:
- Macro: HARRIS_CORNER_LIMIT_EN
- Defined:
  - Adds input max_corners[CNT_W-1:0] and output corner_ovf.
  - Once the running count equals max_corners, further corner_valid strobes are suppressed.
  - corner_ovf=1 is latched until the next sof or reset.
  - corner_count reports max_corners.
- Undefined: no extra ports; every qualifying corner is reported.

Test Plan:
- Parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=6, LATENCY=4, BORDER=1.
- Continuous pix_valid for 48 cycles after sof, corner_in=0 → det_clk_en high for 48 cycles, then 4 DRAIN cycles; frame_done one cycle later; corner_count=0; busy low after DONE.
- corner_in forced 1 for all output positions → corner_valid only for x 1..6, y 1..4: 24 strobes, first at (1,1); corner_count=24.
- pix_valid toggling 1/0 → det_clk_en mirrors pix_valid; output positions and corner_x/corner_y are identical to the continuous case; frame spans 95 ACTIVE cycles.
- cfg_load with threshold=1000, scale=4 mid-frame → det_threshold/det_scale unchanged until next sof, then 1000/4.
- sof after 20 pixels → frame_err=1, no frame_done, new frame completes normally. Assert reset mid-DRAIN → all outputs 0 and IDLE immediately.
- With HARRIS_CORNER_LIMIT_EN, max_corners=5, all corners asserted → exactly 5 corner_valid, corner_ovf=1, corner_count=5.

Source files
------------

// File: rtl/harris_frame_ctrl.sv
// Harris frame sequencer: detector clk_en, end-of-frame drain, decision->(x,y) mapping, border mask, per-frame corner count.
// Optional HARRIS_CORNER_LIMIT_EN adds max_corners/corner_ovf to cap the corners reported per frame.
module harris_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LATENCY  = 1283,
  parameter int BORDER   = 3,
  parameter int CNT_W    = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sof,
  input  logic               pix_valid,
  input  logic               corner_in,
  input  logic signed [17:0] cfg_threshold,
  input  logic [7:0]         cfg_scale,
  input  logic               cfg_load,
  output logic               det_clk_en,
  output logic signed [17:0] det_threshold,
  output logic [7:0]         det_scale,
  output logic               corner_valid,
  output logic [9:0]         corner_x,
  output logic [8:0]         corner_y,
  output logic               frame_done,
  output logic [CNT_W-1:0]   corner_count,
  output logic               frame_err,
  output logic               busy
`ifdef HARRIS_CORNER_LIMIT_EN
  ,
  input  logic [CNT_W-1:0]   max_corners,
  output logic               corner_ovf
`endif
);

  localparam int NPIX  = H_ACTIVE * V_ACTIVE;
  localparam int IN_W  = $clog2(NPIX + 1);
  localparam int TOT_W = $clog2(NPIX + LATENCY + 1);
  localparam int DR_W  = $clog2(LATENCY + 1);
  localparam logic [IN_W-1:0]  IN_LAST = IN_W'(NPIX - 1);
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(LATENCY - 1);
  localparam logic [TOT_W-1:0] TOT_LAT = TOT_W'(LATENCY);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] X_LO   = 10'(BORDER);
  localparam logic [9:0] X_HI   = 10'(H_ACTIVE - BORDER);
  localparam logic [8:0] Y_LO   = 9'(BORDER);
  localparam logic [8:0] Y_HI   = 9'(V_ACTIVE - BORDER);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [IN_W-1:0]    in_cnt_q;
  logic [DR_W-1:0]    drain_q;
  logic [TOT_W-1:0]   tot_q;
  logic               en_d_q;
  logic [9:0]         ox_q;
  logic [8:0]         oy_q;
  logic [CNT_W-1:0]   run_q, run_d, count_q;
  logic signed [17:0] pend_thr_q, thr_q, thr_d;
  logic [7:0]         pend_sc_q, sc_q, sc_d;
  logic               cv_q, err_q;
  logic [9:0]         cx_q;
  logic [8:0]         cy_q;
  logic               produce, in_box, hit_raw, hit;

  assign det_clk_en = (state_q == ACTIVE && pix_valid) || (state_q == DRAIN);
  // en_d_q aligns with corner_in; the first LATENCY enables only fill the window.
  assign produce = en_d_q && (tot_q > TOT_LAT);
  assign in_box  = (ox_q >= X_LO) && (ox_q < X_HI) && (oy_q >= Y_LO) && (oy_q < Y_HI);
  assign hit_raw = produce && corner_in && in_box;

`ifdef HARRIS_CORNER_LIMIT_EN
  logic ovf_q;
  assign hit        = hit_raw && (run_q != max_corners);
  assign corner_ovf = ovf_q;
`else
  assign hit = hit_raw;
`endif

  assign run_d = (hit && run_q != '1) ? run_q + CNT_W'(1) : run_q;
  // A same-cycle cfg_load lands in pending first, so sof picks it up.
  assign thr_d = cfg_load ? cfg_threshold : pend_thr_q;
  assign sc_d  = cfg_load ? cfg_scale : pend_sc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      drain_q    <= '0;
      tot_q      <= '0;
      en_d_q     <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      run_q      <= '0;
      count_q    <= '0;
      pend_thr_q <= '0;
      pend_sc_q  <= '0;
      thr_q      <= '0;
      sc_q       <= '0;
      cv_q       <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      err_q      <= 1'b0;
`ifdef HARRIS_CORNER_LIMIT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      if (cfg_load) begin
        pend_thr_q <= cfg_threshold;
        pend_sc_q  <= cfg_scale;
      end
      cv_q <= hit && !sof;
      if (hit) begin
        cx_q <= ox_q;
        cy_q <= oy_q;
      end
      if (sof) begin
        if (state_q != IDLE) err_q <= 1'b1;
        thr_q    <= thr_d;
        sc_q     <= sc_d;
        state_q  <= ACTIVE;
        in_cnt_q <= '0;
        drain_q  <= '0;
        tot_q    <= '0;
        en_d_q   <= 1'b0;
        ox_q     <= '0;
        oy_q     <= '0;
        run_q    <= '0;
`ifdef HARRIS_CORNER_LIMIT_EN
        ovf_q    <= 1'b0;
`endif
      end else begin
        en_d_q <= det_clk_en;
        if (det_clk_en) tot_q <= tot_q + TOT_W'(1);
        if (produce) begin
          if (ox_q == X_LAST) begin
            ox_q <= '0;
            oy_q <= oy_q + 9'd1;
          end else begin
            ox_q <= ox_q + 10'd1;
          end
        end
        run_q <= run_d;
`ifdef HARRIS_CORNER_LIMIT_EN
        if (hit_raw && !hit) ovf_q <= 1'b1;
`endif
        case (state_q)
          ACTIVE: begin
            if (pix_valid) begin
              in_cnt_q <= in_cnt_q + IN_W'(1);
              if (in_cnt_q == IN_LAST) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            drain_q <= drain_q + DR_W'(1);
            if (drain_q == DR_LAST) state_q <= DONE;
          end
          DONE: begin
            count_q <= run_d;
            state_q <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign det_threshold = thr_q;
  assign det_scale     = sc_q;
  assign corner_valid  = cv_q;
  assign corner_x      = cx_q;
  assign corner_y      = cy_q;
  assign frame_done    = (state_q == DONE) && !sof;
  assign corner_count  = count_q;
  assign frame_err     = err_q;
  assign busy          = (state_q == ACTIVE) || (state_q == DRAIN);

endmodule
